model_irq_ctrl: RTL
===================

Name: model_irq_ctrl

Overview:
- Avalon-MM interrupt aggregator directly downstream of model_timer_0 and other peripheral slaves; consumes their level `irq` outputs.
- Latches a rising edge on each source into a sticky pending bit and applies a software mask.
- Drives a single registered `irq` to the CPU and exposes pending, mask and a priority vector over the same 16-bit, 3-bit-address register bus the timer uses.

Parameters:
NUM_IRQ, 8, number of interrupt sources, legal range 1..16; source 0 is the timer.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  16  write data
readdata  output  16  registered read data
irq_in  input  NUM_IRQ  peripheral interrupt levels, synchronous to clk
irq  output  1  aggregated interrupt to CPU

Behaviour:
- One clock `clk`. Asynchronous active-low reset `reset_n`. All flops reset on the falling edge of `reset_n`.
- Write strobe: wr_k = chipselect && ~write_n && (address == k).
- Edge detect: irq_d <= irq_in every cycle, reset 0. edge = irq_in & ~irq_d.
  - A source already high when reset releases registers as an edge on the first clock.
- pending[NUM_IRQ-1:0], reset 0.
  - next = (pending & ~clr) | edge | force.
  - clr = writedata bits when wr_0; force = writedata bits when wr_5.
  - Set wins over a clear in the same cycle.
- mask, reset 0. Loaded from writedata[NUM_IRQ-1:0] on wr_1.
- act = pending & mask.
- irq <= |act, registered, reset 0.
  - Latency: an irq_in rise sampled at edge t gives pending set after t and irq high after t+1.
  - irq falls one cycle after the W1C write or mask write that empties act.
- Vector: valid = |act; idx = lowest-numbered set bit of act (source 0 has highest priority); idx = 0 when valid = 0.
- Register map (reads):
  - 0: PENDING
  - 1: MASK
  - 2: act
  - 3: {valid, 11'b0, idx[3:0]}
  - 4: irq_d (raw level)
  - 5: 0
  - 6: MISSED (optional feature), else 0
  - 7: 0
- Register bits at or above NUM_IRQ read 0. Writes to read-only addresses (2, 3, 4, 7) are ignored.
- readdata <= mux(address) every cycle, reset 0. It is not gated by chipselect, giving one-cycle read latency.
- A level held high on irq_in does not re-set pending after a W1C; only a new 0→1 transition does.
- Masked sources still accumulate pending. Unmasking a pending source asserts irq one cycle after the MASK write.
- Reset mid-operation clears pending, mask, irq and readdata immediately.

Optional Feature:
MODEL_IRQ_CTRL_MISSED_EN
- Defined:
  - A 16-bit MISSED counter (reset 0) increments on any cycle where (edge & pending) != 0, i.e. a new edge on an already-pending source. Increment is by 1 per cycle regardless of how many sources collide.
  - Saturates at 16'hFFFF.
  - Readable at address 6. Any write to address 6 clears it; a clear wins over a simultaneous increment.
- Undefined: no counter logic; address 6 reads 0; writes to it are ignored.

Test Plan:
1. Reset release with irq_in=0 → readdata=0, irq=0; read address 1 → 16'h0000.
2. MASK=16'h0001; pulse irq_in[0] 0→1 → PENDING=16'h0001 after one clock, irq=1 one clock later; VECTOR read=16'h8000; write 16'h0001 to address 0 → irq=0 next cycle, irq_in[0] still high does not re-pend.
3. MASK=16'h00FF; raise irq_in[5] and irq_in[2] together → act=16'h0024, VECTOR=16'h8002; clear bit 2 → VECTOR=16'h8005.
4. W1C of bit 3 on the same cycle as an irq_in[3] rise → PENDING bit 3 stays 1.
5. MASK=0; write 16'h0010 to address 5 → PENDING=16'h0010, irq=0; write MASK=16'h0010 → irq=1 one cycle after the write.
6. With MODEL_IRQ_CTRL_MISSED_EN: three edges on irq_in[1] without clearing → address 6 reads 16'h0002; write address 6 → reads 16'h0000. Without the macro → address 6 reads 16'h0000.

Source files
------------

// File: rtl/model_irq_ctrl.sv
// ---------------------------------------------------------------------------
// model_irq_ctrl -- Avalon-MM interrupt aggregator.
//
// Each peripheral level irq_in[i] is edge-detected into a sticky pending bit,
// gated by a software mask and OR-reduced into one registered irq to the CPU.
// A priority vector (lowest-numbered active source wins) is readable too.
//
// Optional feature macro: MODEL_IRQ_CTRL_MISSED_EN
//   When defined, a saturating 16-bit MISSED counter at address 6 counts
//   cycles in which a new edge lands on an already-pending source.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (3 bits)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    registered read data, one-cycle latency, not chipselect-gated
//   irq_in      peripheral interrupt levels (synchronous to clk)
//   irq         aggregated registered interrupt to CPU
//
// Register map: 0 PENDING (W1C), 1 MASK, 2 ACT, 3 VECTOR {valid,11'b0,idx},
//               4 raw level, 5 FORCE (write-only, reads 0), 6 MISSED, 7 zero.
// ---------------------------------------------------------------------------
module model_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  // Zero-extend a per-source vector to the 16-bit bus.
  function automatic logic [15:0] pad(input logic [NUM_IRQ-1:0] v);
    pad = '0;
    pad[NUM_IRQ-1:0] = v;
  endfunction

  logic [NUM_IRQ-1:0] irq_d_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic               irq_q;
  logic [15:0]        readdata_q, readdata_d;

  logic               wr_en;
  logic               wr_0, wr_1, wr_5;
  logic [NUM_IRQ-1:0] rise, clr, frc, act;
  logic               vec_vld;
  logic [3:0]         vec_idx;

  // Upper writedata bits are unused when NUM_IRQ < 16.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr_en = chipselect && !write_n;
  assign wr_0  = wr_en && (address == 3'd0);
  assign wr_1  = wr_en && (address == 3'd1);
  assign wr_5  = wr_en && (address == 3'd5);

  assign rise  = irq_in & ~irq_d_q;
  assign clr   = wr_0 ? writedata[NUM_IRQ-1:0] : '0;
  assign frc   = wr_5 ? writedata[NUM_IRQ-1:0] : '0;
  // Set (edge or force) overrides a same-cycle W1C.
  assign pending_d = (pending_q & ~clr) | rise | frc;
  assign act   = pending_q & mask_q;

  // Priority encode: scan downward so the lowest set bit is the last written.
  always_comb begin
    vec_vld = |act;
    vec_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i]) vec_idx = i[3:0];
    end
  end

`ifdef MODEL_IRQ_CTRL_MISSED_EN
  logic [15:0] missed_q;
  logic        wr_6;
  assign wr_6 = wr_en && (address == 3'd6);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      missed_q <= '0;
    end else if (wr_6) begin
      missed_q <= '0;                 // clear beats a same-cycle increment
    end else if (|(rise & pending_q) && (missed_q != 16'hFFFF)) begin
      missed_q <= missed_q + 16'd1;
    end
  end
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0: readdata_d = pad(pending_q);
      3'd1: readdata_d = pad(mask_q);
      3'd2: readdata_d = pad(act);
      3'd3: readdata_d = {vec_vld, 11'b0, vec_idx};
      3'd4: readdata_d = pad(irq_d_q);
`ifdef MODEL_IRQ_CTRL_MISSED_EN
      3'd6: readdata_d = missed_q;
`endif
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_d_q    <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      irq_d_q    <= irq_in;
      pending_q  <= pending_d;
      if (wr_1) mask_q <= writedata[NUM_IRQ-1:0];
      irq_q      <= |act;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
